// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes (common with the alu_control producer)
// and default datapath widths for the execute stage.
package alu_pkg;

    localparam int unsigned ALU_DATA_W  = 32;
    localparam int unsigned ALU_TAG_W   = 5;
    localparam int unsigned ALU_CTRL_W  = 5;
    localparam int unsigned ALU_SHAMT_W = 5;

    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 5'd0;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 5'd1;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 5'd2;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLLV = 5'd3;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRLV = 5'd4;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRAV = 5'd5;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 5'd6;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADDU = 5'd7;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 5'd8;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUBU = 5'd9;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 5'd10;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 5'd11;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 5'd12;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR  = 5'd13;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 5'd14;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 5'd15;
    localparam logic [ALU_CTRL_W-1:0] ALU_LUI  = 5'd16;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Execute-stage bus: upstream beat (in_*), downstream beat (out_*) and flush.
// slave  : the execute stage (consumes in_*, produces out_*)
// master : the environment driving the stage (decoder side + MEM side)
interface alu_exec_stage_if #(
    parameter int unsigned DATA_W = alu_pkg::ALU_DATA_W,
    parameter int unsigned TAG_W  = alu_pkg::ALU_TAG_W
);
    import alu_pkg::*;

    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [ALU_CTRL_W-1:0]  in_ctrl;
    logic [ALU_SHAMT_W-1:0] in_shamt;
    logic [DATA_W-1:0]      in_a;
    logic [DATA_W-1:0]      in_b;
    logic [TAG_W-1:0]       in_dest;
    logic                   in_wen;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_result;
    logic [TAG_W-1:0]       out_dest;
    logic                   out_wen;
    logic                   out_ovf;

    modport slave (
        input  flush, in_valid, in_ctrl, in_shamt, in_a, in_b, in_dest, in_wen, out_ready,
        output in_ready, out_valid, out_result, out_dest, out_wen, out_ovf
    );

    modport master (
        output flush, in_valid, in_ctrl, in_shamt, in_a, in_b, in_dest, in_wen, out_ready,
        input  in_ready, out_valid, out_result, out_dest, out_wen, out_ovf
    );

endinterface

// File: rtl/alu_core.sv
// Purely combinational MIPS ALU: (ctrl, shamt, a, b) -> (result, ovf).
// Ports: ctrl/shamt from the decoder, a/b operands, result, ovf (signed
// overflow of add/sub). Undefined codes give result 0 and no overflow.
// Macro ALU_OVF_TRAP_EN: when undefined, ovf is tied 0 so add/sub act as addu/subu.
module alu_core #(
    parameter int unsigned DATA_W = alu_pkg::ALU_DATA_W
) (
    input  logic [alu_pkg::ALU_CTRL_W-1:0]  ctrl,
    input  logic [alu_pkg::ALU_SHAMT_W-1:0] shamt,
    input  logic [DATA_W-1:0]               a,
    input  logic [DATA_W-1:0]               b,
    output logic [DATA_W-1:0]               result,
    output logic                            ovf
);
    import alu_pkg::*;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

`ifdef ALU_OVF_TRAP_EN
    // Signed wrap: like-signed add or unlike-signed sub whose sign flips.
    logic add_ovf;
    logic sub_ovf;
    assign add_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1]  != a[DATA_W-1]);
    assign sub_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
`endif

    // Operation select.
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (ctrl)
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = DATA_W'($signed(b) >>> shamt);
            ALU_SLLV: result = b << a[4:0];
            ALU_SRLV: result = b >> a[4:0];
            ALU_SRAV: result = DATA_W'($signed(b) >>> a[4:0]);
            ALU_ADD: begin
                result = sum;
`ifdef ALU_OVF_TRAP_EN
                ovf    = add_ovf;
`endif
            end
            ALU_ADDU: result = sum;
            ALU_SUB: begin
                result = diff;
`ifdef ALU_OVF_TRAP_EN
                ovf    = sub_ovf;
`endif
            end
            ALU_SUBU: result = diff;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = DATA_W'($signed(a) < $signed(b));
            ALU_SLTU: result = DATA_W'(a < b);
            ALU_LUI:  result = {b[15:0], 16'h0000};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// MIPS execute stage: 2-stage valid/ready pipeline (S1 operand latch, S2
// result register) around alu_core, with back-pressure and synchronous flush.
// Ports: clk, rst (synchronous, active high), bus (alu_exec_stage_if.slave:
// flush, in_* upstream beat with in_ready, out_* downstream beat with out_ready).
// Macro ALU_OVF_TRAP_EN: when defined, a signed overflow on add/sub raises
// out_ovf and suppresses out_wen; when undefined out_ovf is always 0.
module alu_exec_stage #(
    parameter int unsigned DATA_W = alu_pkg::ALU_DATA_W,
    parameter int unsigned TAG_W  = alu_pkg::ALU_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    alu_exec_stage_if.slave  bus
);
    import alu_pkg::*;

    logic                   s1_valid;
    logic [ALU_CTRL_W-1:0]  s1_ctrl;
    logic [ALU_SHAMT_W-1:0] s1_shamt;
    logic [DATA_W-1:0]      s1_a;
    logic [DATA_W-1:0]      s1_b;
    logic [TAG_W-1:0]       s1_dest;
    logic                   s1_wen;

    logic                   s2_adv;
    logic [DATA_W-1:0]      alu_result;
    logic                   alu_ovf;

    // S2 can take a new beat when empty or being drained this cycle.
    assign s2_adv      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_adv;

    alu_core #(.DATA_W(DATA_W)) u_core (
        .ctrl   (s1_ctrl),
        .shamt  (s1_shamt),
        .a      (s1_a),
        .b      (s1_b),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    // Pipeline registers; flush kills valids only, data may stay stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            s1_ctrl        <= '0;
            s1_shamt       <= '0;
            s1_a           <= '0;
            s1_b           <= '0;
            s1_dest        <= '0;
            s1_wen         <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_dest   <= '0;
            bus.out_wen    <= 1'b0;
            bus.out_ovf    <= 1'b0;
        end else if (bus.flush) begin
            s1_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.out_result <= alu_result;
                    bus.out_dest   <= s1_dest;
                    // alu_ovf is only ever set when trapping is enabled.
                    bus.out_wen    <= s1_wen & ~alu_ovf;
                    bus.out_ovf    <= alu_ovf;
                end
            end
            if (bus.in_ready) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_ctrl  <= bus.in_ctrl;
                    s1_shamt <= bus.in_shamt;
                    s1_a     <= bus.in_a;
                    s1_b     <= bus.in_b;
                    s1_dest  <= bus.in_dest;
                    s1_wen   <= bus.in_wen;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vectors, an in-bench
// scoreboard model, and literal expectations for the documented cases.
module tb_alu_exec_stage;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_exec_stage_if bus ();

    alu_exec_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] r;
        logic [4:0]  d;
        logic        w;
        logic        o;
        int          k;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   out_cnt = 0;
    logic chk_en = 1'b0;
    exp_t sb_q[$];
    exp_t pend;
    logic acc_pend = 1'b0;
    logic pop_pend = 1'b0;
    logic exp_v;
    logic exp_rdy;

    logic [4:0]  bc[32];
    logic [4:0]  bs[32];
    logic [31:0] ba[32];
    logic [31:0] bb[32];
    logic [4:0]  bd[32];
    logic        bw[32];
    int          nb = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference ALU written from the instruction definitions.
    function automatic exp_t model(input logic [4:0] c, input logic [4:0] sh,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] d, input logic w);
        exp_t   e;
        longint s;
        int     bi;
        bi  = $signed(b);
        e.r = 32'd0;
        e.o = 1'b0;
        e.d = d;
        e.k = 0;
        case (c)
            5'd0:  e.r = b << sh;
            5'd1:  e.r = b >> sh;
            5'd2:  e.r = 32'(bi >>> sh);
            5'd3:  e.r = b << a[4:0];
            5'd4:  e.r = b >> a[4:0];
            5'd5:  e.r = 32'(bi >>> a[4:0]);
            5'd6, 5'd7: begin
                s   = longint'($signed(a)) + longint'($signed(b));
                e.r = s[31:0];
                if (c == 5'd6) e.o = (s != longint'($signed(e.r)));
            end
            5'd8, 5'd9: begin
                s   = longint'($signed(a)) - longint'($signed(b));
                e.r = s[31:0];
                if (c == 5'd8) e.o = (s != longint'($signed(e.r)));
            end
            5'd10: e.r = a & b;
            5'd11: e.r = a | b;
            5'd12: e.r = a ^ b;
            5'd13: e.r = ~(a | b);
            5'd14: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd15: e.r = (a < b) ? 32'd1 : 32'd0;
            5'd16: e.r = {b[15:0], 16'h0000};
            default: e.r = 32'd0;
        endcase
`ifdef ALU_OVF_TRAP_EN
        e.w = w && !e.o;
`else
        e.o = 1'b0;
        e.w = w;
`endif
        return e;
    endfunction

    // Compare process: DUT against the scoreboard on every falling edge.
    always @(negedge clk) begin
        acc_pend = 1'b0;
        pop_pend = 1'b0;
        if (chk_en) begin
            exp_v   = (sb_q.size() > 0) && (edge_cnt >= sb_q[0].k + 1);
            exp_rdy = (sb_q.size() < 2) || bus.out_ready;
            chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
            chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            if (exp_v && bus.out_valid) begin
                chk("out_result", bus.out_result, sb_q[0].r);
                chk("out_dest", 32'(bus.out_dest), 32'(sb_q[0].d));
                chk("out_wen", 32'(bus.out_wen), 32'(sb_q[0].w));
                chk("out_ovf", 32'(bus.out_ovf), 32'(sb_q[0].o));
            end
            pop_pend = exp_v && bus.out_ready;
            acc_pend = bus.in_valid && exp_rdy && !bus.flush && !rst;
            if (acc_pend)
                pend = model(bus.in_ctrl, bus.in_shamt, bus.in_a, bus.in_b, bus.in_dest, bus.in_wen);
        end
    end

    // Model state update on the active edge.
    always @(posedge clk) begin
        edge_cnt++;
        if (pop_pend) out_cnt++;
        if (rst || bus.flush) begin
            sb_q.delete();
        end else begin
            if (pop_pend) void'(sb_q.pop_front());
            if (acc_pend) begin
                pend.k = edge_cnt;
                sb_q.push_back(pend);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] c, input logic [4:0] sh, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d, input logic w);
        bus.in_valid = 1'b1;
        bus.in_ctrl  = c;
        bus.in_shamt = sh;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_dest  = d;
        bus.in_wen   = w;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.out_valid) begin
            errors++;
            $display("FAIL %s: out_valid got 0 expected 1 within 10 cycles", name);
        end
    endtask

    task automatic add_beat(input logic [4:0] c, input logic [4:0] sh, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] d, input logic w);
        bc[nb] = c; bs[nb] = sh; ba[nb] = a; bb[nb] = b; bd[nb] = d; bw[nb] = w;
        nb++;
    endtask

    // Offer queued beats in order; out_ready held low for the first 'stall' cycles.
    task automatic run_stream(input int stall, input string name);
        int   idx = 0;
        int   cyc = 0;
        logic acc;
        while (idx < nb && cyc < 100) begin
            bus.out_ready = (cyc >= stall);
            drive(bc[idx], bs[idx], ba[idx], bb[idx], bd[idx], bw[idx]);
            @(negedge clk);
            acc = bus.in_ready;
            if (stall >= 3 && cyc == 2)
                chk({name, "_in_ready_full"}, 32'(bus.in_ready), 32'd0);
            tick();
            if (acc) idx++;
            cyc++;
        end
        checks++;
        if (idx != nb) begin
            errors++;
            $display("FAIL %s_accept: got %0d beats accepted expected %0d", name, idx, nb);
        end
        idle();
        bus.out_ready = 1'b1;
        nb = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   cnt0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_ctrl   = '0;
        bus.in_shamt  = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_dest   = '0;
        bus.in_wen    = 1'b0;

        // Hand-computed pins of the model itself.
        e = model(5'd6, 5'd0, 32'h7FFF_FFFF, 32'h1, 5'd3, 1'b1);
        chk("model_add_res", e.r, 32'h8000_0000);
`ifdef ALU_OVF_TRAP_EN
        chk("model_add_ovf", 32'(e.o), 32'd1);
        chk("model_add_wen", 32'(e.w), 32'd0);
`else
        chk("model_add_ovf", 32'(e.o), 32'd0);
        chk("model_add_wen", 32'(e.w), 32'd1);
`endif
        e = model(5'd2, 5'd4, 32'h0, 32'hF000_0000, 5'd0, 1'b0);
        chk("model_sra", e.r, 32'hFF00_0000);
        e = model(5'd14, 5'd0, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0);
        chk("model_slt", e.r, 32'h1);
        e = model(5'd15, 5'd0, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0);
        chk("model_sltu", e.r, 32'h0);
        e = model(5'd16, 5'd0, 32'h0, 32'h0000_1234, 5'd0, 1'b0);
        chk("model_lui", e.r, 32'h1234_0000);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_out_dest", 32'(bus.out_dest), 32'd0);
        chk("rst_out_wen", 32'(bus.out_wen), 32'd0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk_en = 1'b1;
        tick();
        rst = 1'b0;

        // Case 1: signed add overflow.
        drive(5'd6, 5'd0, 32'h7FFF_FFFF, 32'h1, 5'd3, 1'b1);
        tick();
        idle();
        wait_out("t1_wait");
        chk("t1_result", bus.out_result, 32'h8000_0000);
`ifdef ALU_OVF_TRAP_EN
        chk("t1_ovf", 32'(bus.out_ovf), 32'd1);
        chk("t1_wen", 32'(bus.out_wen), 32'd0);
`else
        chk("t1_ovf", 32'(bus.out_ovf), 32'd0);
        chk("t1_wen", 32'(bus.out_wen), 32'd1);
`endif
        tick();

        // Case 2: sra then srav, back to back, 2-cycle latency.
        drive(5'd2, 5'd4, 32'h0, 32'hF000_0000, 5'd5, 1'b1);
        @(negedge clk);
        chk("t2_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        drive(5'd5, 5'd0, 32'h4, 32'hF000_0000, 5'd6, 1'b1);
        @(negedge clk);
        chk("t2_lat_not_yet", 32'(bus.out_valid), 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("t2_a_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_a_result", bus.out_result, 32'hFF00_0000);
        chk("t2_a_dest", 32'(bus.out_dest), 32'd5);
        tick();
        @(negedge clk);
        chk("t2_b_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_b_result", bus.out_result, 32'hFF00_0000);
        chk("t2_b_dest", 32'(bus.out_dest), 32'd6);
        tick();

        // Case 3 and a sweep of the remaining codes at full throughput.
        add_beat(5'd14, 5'd0,  32'hFFFF_FFFF, 32'h1,          5'd1,  1'b1);
        add_beat(5'd15, 5'd0,  32'hFFFF_FFFF, 32'h1,          5'd2,  1'b1);
        add_beat(5'd16, 5'd0,  32'h0,         32'h0000_1234,  5'd3,  1'b1);
        add_beat(5'd0,  5'd31, 32'h0,         32'h1,          5'd4,  1'b0);
        add_beat(5'd1,  5'd1,  32'h0,         32'h8000_0000,  5'd5,  1'b1);
        add_beat(5'd3,  5'd0,  32'h24,        32'h1,          5'd6,  1'b1);
        add_beat(5'd4,  5'd0,  32'h1F,        32'h8000_0000,  5'd7,  1'b1);
        add_beat(5'd7,  5'd0,  32'hFFFF_FFFF, 32'h1,          5'd8,  1'b1);
        add_beat(5'd8,  5'd0,  32'h8000_0000, 32'h1,          5'd9,  1'b1);
        add_beat(5'd9,  5'd0,  32'h8000_0000, 32'h1,          5'd10, 1'b1);
        add_beat(5'd6,  5'd0,  32'h8000_0000, 32'h8000_0000,  5'd11, 1'b1);
        add_beat(5'd10, 5'd0,  32'hF0F0_F0F0, 32'h0FF0_0FF0,  5'd12, 1'b1);
        add_beat(5'd11, 5'd0,  32'hF0F0_F0F0, 32'h0FF0_0FF0,  5'd13, 1'b1);
        add_beat(5'd12, 5'd0,  32'hF0F0_F0F0, 32'h0FF0_0FF0,  5'd14, 1'b1);
        add_beat(5'd13, 5'd0,  32'hF0F0_F0F0, 32'h0FF0_0FF0,  5'd15, 1'b1);
        add_beat(5'd6,  5'd0,  32'h5,         32'h7,          5'd16, 1'b1);
        add_beat(5'd8,  5'd0,  32'h7FFF_FFFF, 32'hFFFF_FFFF,  5'd17, 1'b1);
        add_beat(5'd20, 5'd3,  32'h1234_5678, 32'h9ABC_DEF0,  5'd18, 1'b1);
        run_stream(0, "t3");
        repeat (4) tick();

        // Case 4: four beats against a 3-cycle downstream stall.
        cnt0 = out_cnt;
        add_beat(5'd7,  5'd0, 32'h1, 32'h2, 5'd21, 1'b1);
        add_beat(5'd7,  5'd0, 32'h3, 32'h4, 5'd22, 1'b1);
        add_beat(5'd11, 5'd0, 32'h5, 32'h8, 5'd23, 1'b1);
        add_beat(5'd9,  5'd0, 32'h9, 32'hA, 5'd24, 1'b0);
        run_stream(3, "t4");
        repeat (5) tick();
        chk("t4_beats_out", 32'(out_cnt - cnt0), 32'd4);
        chk("t4_drained", 32'(sb_q.size()), 32'd0);

        // Case 5: flush with both stages full and a beat offered.
        cnt0 = out_cnt;
        bus.out_ready = 1'b0;
        drive(5'd7, 5'd0, 32'h10, 32'h20, 5'd25, 1'b1);
        tick();
        drive(5'd7, 5'd0, 32'h30, 32'h40, 5'd26, 1'b1);
        tick();
        drive(5'd7, 5'd0, 32'h50, 32'h60, 5'd27, 1'b1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        idle();
        @(negedge clk);
        chk("t5_flush_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        repeat (4) tick();
        // Flush with an empty pipeline while in_ready is high.
        drive(5'd7, 5'd0, 32'h70, 32'h80, 5'd28, 1'b1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        idle();
        repeat (4) tick();
        chk("t5_no_emit", 32'(out_cnt - cnt0), 32'd0);
        drive(5'd11, 5'd0, 32'hA5A5_0000, 32'h0000_5A5A, 5'd29, 1'b1);
        tick();
        idle();
        wait_out("t5_recover_wait");
        chk("t5_recover_result", bus.out_result, 32'hA5A5_5A5A);
        tick();

        // Case 6: reset during a stall, then an undefined code.
        bus.out_ready = 1'b0;
        drive(5'd7, 5'd0, 32'h1, 32'h1, 5'd30, 1'b1);
        tick();
        drive(5'd7, 5'd0, 32'h2, 32'h2, 5'd31, 1'b1);
        tick();
        idle();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rst_out_result", bus.out_result, 32'd0);
        chk("t6_rst_out_dest", 32'(bus.out_dest), 32'd0);
        chk("t6_rst_out_wen", 32'(bus.out_wen), 32'd0);
        chk("t6_rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        cnt0 = out_cnt;
        repeat (3) tick();
        chk("t6_no_emit_after_rst", 32'(out_cnt - cnt0), 32'd0);
        drive(5'd31, 5'd7, 32'h1234, 32'h5678, 5'd0, 1'b0);
        tick();
        idle();
        wait_out("t6_wait");
        chk("t6_result", bus.out_result, 32'd0);
        chk("t6_dest", 32'(bus.out_dest), 32'd0);
        chk("t6_wen", 32'(bus.out_wen), 32'd0);
        chk("t6_ovf", 32'(bus.out_ovf), 32'd0);
        repeat (3) tick();
        chk("final_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
